xgemac_tx_pkt_buffer: RTL and testbench
=======================================

XGEMAC_TX_PKT_BUFFER -- requirements
Module: xgemac_tx_pkt_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data bus width in bits; a multiple of 8 and at least 16.
REQ-002 Parameter MOD_WIDTH, default 3, byte-count field width; equals log2(DATA_WIDTH/8).
REQ-003 Parameter DEPTH, default 16, FIFO depth in words; a power of two, at least 4.
REQ-004 Parameter STORE_FWD, default 0, where 0 selects cut-through and 1 selects store-and-forward.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  DATA_WIDTH  ingress packet word.
REQ-008 in_val  input  1  ingress word valid.
REQ-009 in_sop  input  1  first word of packet.
REQ-010 in_eop  input  1  last word of packet.
REQ-011 in_mod  input  MOD_WIDTH  valid bytes in eop word; 0 means all bytes valid.
REQ-012 in_ready  output  1  ingress may accept a word this cycle.
REQ-013 pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod  output  DATA_WIDTH/1/1/1/MOD_WIDTH  registered MAC transmit interface.
REQ-014 pkt_tx_full  input  1  MAC FIFO almost-full backpressure.
REQ-015 framing_err  output  1  one-cycle pulse per framing violation.
REQ-016 pkt_cnt  output  32  packets delivered to MAC; wraps.
REQ-017 err_cnt  output  16  framing violations; saturates at 16'hFFFF.

Function
REQ-018 Ingress transfer: the block SHALL accept a word only at a rising edge where in_val=1 and in_ready=1.
REQ-019 in_ready SHALL equal (fifo_count < DEPTH); a read in the same cycle gives no bypass.
REQ-020 The ingress FSM SHALL have two states, IDLE and IN_PKT.
- IDLE moves to IN_PKT on an accepted sop word without eop.
- IN_PKT moves to IDLE on an accepted eop word.
REQ-021 A word accepted in IDLE without in_sop SHALL be discarded, not written; framing_err pulses and err_cnt increments.
REQ-022 An in_sop word accepted in IN_PKT SHALL be written with its sop bit cleared, treated as a continuation; framing_err pulses.
REQ-023 A word with sop=1 and eop=1 SHALL be a legal single-word packet.
REQ-024 The FIFO SHALL store data, sop, eop and mod per word; stored mod is forced to 0 unless eop=1.
REQ-025 Egress FSM states SHALL be IDLE and XFER.
REQ-026 IDLE moves to XFER when the head word is a sop word and the start condition holds.
- Cut-through: the FIFO is non-empty.
- Store-and-forward: complete-packet count > 0.
REQ-027 XFER moves to IDLE after the eop word is loaded into the output register.
REQ-028 The output register SHALL load the next FIFO word only at an edge where pkt_tx_full=0 and a word is eligible; otherwise it loads pkt_tx_val=0.
REQ-029 pkt_tx_sop, pkt_tx_eop and pkt_tx_mod SHALL be 0 whenever pkt_tx_val=0.
REQ-030 Each cycle with pkt_tx_val=1 SHALL count as one word delivered; the MAC is not otherwise handshaked.
REQ-031 In cut-through, a FIFO underrun mid-packet SHALL produce pkt_tx_val=0 gap cycles, and the packet resumes with no reordering.
REQ-032 In store-and-forward, if fifo_count=DEPTH with zero complete packets stored, the head packet SHALL be released in cut-through fashion to prevent deadlock.
REQ-033 Latency: a word accepted at edge k SHALL appear on pkt_tx_* no earlier than after edge k+2, given an empty FIFO, an idle egress and pkt_tx_full=0.
- Store-and-forward: the sop word appears no earlier than 2 edges after its eop is accepted.
REQ-034 pkt_cnt SHALL increment on each output cycle with pkt_tx_val=1 and pkt_tx_eop=1.
REQ-035 The complete-packet count SHALL increment when an eop word is written and decrement when an eop word is read; simultaneous events leave it unchanged.

Reset
REQ-036 While rst=0, all outputs SHALL be 0 immediately and asynchronously, including in_ready=0; the FIFO, pointers, counters and both FSMs clear to IDLE.
REQ-037 Reset mid-packet SHALL discard all buffered words, with no partial-packet completion after release.
REQ-038 On the first edge after rst=1, in_ready SHALL be 1.

Verification
REQ-039 Cut-through, 4-word packet (mod=5 on eop), pkt_tx_full=0 -> pkt_tx_val high 4 contiguous cycles starting 2 edges after sop accepted; sop on word 0, eop+mod=5 on word 3; pkt_cnt=1.
REQ-040 STORE_FWD=1, 3-word packet with in_val gaps -> no pkt_tx_val until eop accepted; then 3 contiguous words.
REQ-041 pkt_tx_full held 1 for 5 cycles mid-packet -> pkt_tx_val=0 throughout; delivery resumes in order, with no lost or duplicated words.
REQ-042 DEPTH=4, 6 words written with egress blocked -> in_ready=0 after the 4th; STORE_FWD=1 with a 6-word packet -> forced release, all 6 words delivered.
REQ-043 Non-sop word in IDLE, then sop inside a packet -> 2 framing_err pulses, err_cnt=2; the first word is absent from output, and the second is delivered with sop=0.
REQ-044 rst asserted with 2 words buffered -> outputs 0 at once; after release, no stale words and pkt_cnt=0.

Source files
------------

// File: rtl/xgemac_tx_pkt_buffer.sv
// Transmit packet buffer in front of the 10G MAC: framing-checked ingress FIFO
// with cut-through or store-and-forward egress into a registered MAC interface.
module xgemac_tx_pkt_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int MOD_WIDTH  = 3,
   parameter int DEPTH      = 16,
   parameter int STORE_FWD  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_val,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [MOD_WIDTH-1:0]  in_mod,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] pkt_tx_data,
   output logic                  pkt_tx_val,
   output logic                  pkt_tx_sop,
   output logic                  pkt_tx_eop,
   output logic [MOD_WIDTH-1:0]  pkt_tx_mod,
   input  logic                  pkt_tx_full,
   output logic                  framing_err,
   output logic [31:0]           pkt_cnt,
   output logic [15:0]           err_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  sop;
      logic                  eop;
      logic [MOD_WIDTH-1:0]  mod;
   } word_t;

   typedef enum logic {IN_IDLE, IN_PKT}   in_state_t;
   typedef enum logic {EG_IDLE, EG_XFER}  eg_state_t;

   word_t       mem [DEPTH];
   word_t       head;
   in_state_t   in_st, in_nxt;
   eg_state_t   eg_st, eg_nxt;
   logic [AW:0] wr_ptr, wr_vis, rd_ptr;
   logic [AW:0] fifo_count, vis_count, cpkt;
   logic        in_acc, wr_en, wr_sop, ferr_d, wr_eop_q;
   logic        start_ok, eligible, rd_en;

   assign fifo_count = wr_ptr - rd_ptr;
   assign vis_count  = wr_vis - rd_ptr;
   assign in_ready   = rst && (fifo_count < FULL_CNT);
   assign in_acc     = in_val && in_ready;
   assign head       = mem[rd_ptr[AW-1:0]];

   // Ingress framing: stray continuation words are dropped, nested sops are demoted.
   always_comb begin
      in_nxt = in_st;
      wr_en  = 1'b0;
      wr_sop = in_sop;
      ferr_d = 1'b0;
      if (in_acc) begin
         case (in_st)
            IN_IDLE: begin
               if (in_sop) begin
                  wr_en = 1'b1;
                  if (!in_eop) in_nxt = IN_PKT;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            IN_PKT: begin
               wr_en  = 1'b1;
               wr_sop = 1'b0;
               ferr_d = in_sop;
               if (in_eop) in_nxt = IN_IDLE;
            end
            default: in_nxt = IN_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {in_data, wr_sop, in_eop, (in_eop ? in_mod : {MOD_WIDTH{1'b0}})};
   end

   // Egress sees writes one edge late (wr_vis), giving the two-edge fill latency;
   // a full FIFO with no complete packet starts anyway so store-and-forward cannot deadlock.
   always_comb begin
      start_ok = (STORE_FWD == 0) || (cpkt != '0) || (vis_count == FULL_CNT);
      eligible = (vis_count != '0) && ((eg_st == EG_XFER) || (head.sop && start_ok));
      rd_en    = eligible && !pkt_tx_full;
      eg_nxt   = eg_st;
      if (rd_en) eg_nxt = head.eop ? EG_IDLE : EG_XFER;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_st       <= IN_IDLE;
         eg_st       <= EG_IDLE;
         wr_ptr      <= '0;
         wr_vis      <= '0;
         rd_ptr      <= '0;
         wr_eop_q    <= 1'b0;
         cpkt        <= '0;
         framing_err <= 1'b0;
         err_cnt     <= '0;
         pkt_cnt     <= '0;
         pkt_tx_val  <= 1'b0;
         pkt_tx_data <= '0;
         pkt_tx_sop  <= 1'b0;
         pkt_tx_eop  <= 1'b0;
         pkt_tx_mod  <= '0;
      end else begin
         in_st       <= in_nxt;
         eg_st       <= eg_nxt;
         wr_vis      <= wr_ptr;
         wr_eop_q    <= wr_en && in_eop;
         framing_err <= ferr_d;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (ferr_d && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         if (pkt_tx_val && pkt_tx_eop) pkt_cnt <= pkt_cnt + 32'd1;
         // cpkt counts complete packets whose eop is already visible to egress
         case ({wr_eop_q, rd_en && head.eop})
            2'b10:   cpkt <= cpkt + 1'b1;
            2'b01:   cpkt <= cpkt - 1'b1;
            default: cpkt <= cpkt;
         endcase
         pkt_tx_val  <= rd_en;
         pkt_tx_data <= rd_en ? head.data : '0;
         pkt_tx_sop  <= rd_en && head.sop;
         pkt_tx_eop  <= rd_en && head.eop;
         pkt_tx_mod  <= rd_en ? head.mod : '0;
      end
   end
endmodule

// File: tb/tb_xgemac_tx_pkt_buffer.sv
// Bench for xgemac_tx_pkt_buffer: cut-through instance (DEPTH 16) and
// store-and-forward instance (DEPTH 4) checked against a word scoreboard.
module tb_xgemac_tx_pkt_buffer;
   localparam int DW = 64;
   localparam int MW = 3;

   typedef struct {
      logic [DW-1:0] d;
      logic          s;
      logic          e;
      logic [MW-1:0] m;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   int            cyc = 0;
   logic [DW-1:0] in_data [2];
   logic          in_val  [2];
   logic          in_sop  [2];
   logic          in_eop  [2];
   logic [MW-1:0] in_mod  [2];
   logic          in_ready[2];
   logic [DW-1:0] tx_data [2];
   logic          tx_val  [2];
   logic          tx_sop  [2];
   logic          tx_eop  [2];
   logic [MW-1:0] tx_mod  [2];
   logic          tx_full [2];
   logic          ferr    [2];
   logic [31:0]   pkt_cnt [2];
   logic [15:0]   err_cnt [2];

   exp_t sb0[$];
   exp_t sb1[$];
   bit   in_st[2];
   int   n_chk = 0, n_err = 0;
   int   val_total[2], last_sop_cyc[2], run[2], last_run[2], ferr_total[2];

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   xgemac_tx_pkt_buffer #(.DATA_WIDTH(DW), .MOD_WIDTH(MW), .DEPTH(16), .STORE_FWD(0)) u_ct (
      .clk(clk), .rst(rst),
      .in_data(in_data[0]), .in_val(in_val[0]), .in_sop(in_sop[0]), .in_eop(in_eop[0]),
      .in_mod(in_mod[0]), .in_ready(in_ready[0]),
      .pkt_tx_data(tx_data[0]), .pkt_tx_val(tx_val[0]), .pkt_tx_sop(tx_sop[0]),
      .pkt_tx_eop(tx_eop[0]), .pkt_tx_mod(tx_mod[0]), .pkt_tx_full(tx_full[0]),
      .framing_err(ferr[0]), .pkt_cnt(pkt_cnt[0]), .err_cnt(err_cnt[0]));

   xgemac_tx_pkt_buffer #(.DATA_WIDTH(DW), .MOD_WIDTH(MW), .DEPTH(4), .STORE_FWD(1)) u_sf (
      .clk(clk), .rst(rst),
      .in_data(in_data[1]), .in_val(in_val[1]), .in_sop(in_sop[1]), .in_eop(in_eop[1]),
      .in_mod(in_mod[1]), .in_ready(in_ready[1]),
      .pkt_tx_data(tx_data[1]), .pkt_tx_val(tx_val[1]), .pkt_tx_sop(tx_sop[1]),
      .pkt_tx_eop(tx_eop[1]), .pkt_tx_mod(tx_mod[1]), .pkt_tx_full(tx_full[1]),
      .framing_err(ferr[1]), .pkt_cnt(pkt_cnt[1]), .err_cnt(err_cnt[1]));

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sb_size(int i);
      return (i == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic void sb_push(int i, exp_t e);
      if (i == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endfunction

   function automatic exp_t sb_pop(int i);
      if (i == 0) return sb0.pop_front();
      return sb1.pop_front();
   endfunction

   // Output monitor: every delivered word is popped from the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (ferr[i]) ferr_total[i]++;
            if (tx_val[i]) begin
               val_total[i]++;
               run[i]++;
               if (tx_sop[i]) last_sop_cyc[i] = cyc;
               chk("sb_has_word", 64'(sb_size(i) != 0), 64'(1));
               if (sb_size(i) != 0) begin
                  e = sb_pop(i);
                  chk("tx_data", tx_data[i], e.d);
                  chk("tx_sop", 64'(tx_sop[i]), 64'(e.s));
                  chk("tx_eop", 64'(tx_eop[i]), 64'(e.e));
                  chk("tx_mod", 64'(tx_mod[i]), 64'(e.m));
               end
               if (tx_eop[i]) begin
                  last_run[i] = run[i];
                  run[i] = 0;
               end
            end else begin
               run[i] = 0;
               chk("idle_ctl", 64'({tx_sop[i], tx_eop[i], tx_mod[i]}), 64'(0));
            end
         end
      end
   end

   // Drives one word and holds it until accepted; applies the framing model on acceptance.
   task automatic send(input int i, input logic [63:0] d, input logic s, input logic e,
                       input logic [2:0] m, input int gap, output int ac);
      bit   rdy;
      int   t;
      exp_t x;
      in_data[i] = d; in_val[i] = 1'b1; in_sop[i] = s; in_eop[i] = e; in_mod[i] = m;
      t = 0;
      do begin
         @(negedge clk);
         rdy = in_ready[i];
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 200);
      in_val[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0; in_mod[i] = '0;
      ac = cyc;
      chk("send_accepted", 64'(rdy), 64'(1));
      if (rdy) begin
         x.d = d; x.e = e; x.m = e ? m : 3'd0;
         if (!in_st[i]) begin
            if (s) begin
               x.s = 1'b1;
               sb_push(i, x);
               in_st[i] = !e;
            end
         end else begin
            x.s = 1'b0;
            sb_push(i, x);
            if (e) in_st[i] = 1'b0;
         end
      end
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int i);
      int t = 0;
      while (sb_size(i) != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_done", 64'(sb_size(i)), 64'(0));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int a_sop, a_eop, a, v0, f0;
      for (int i = 0; i < 2; i++) begin
         in_data[i] = '0; in_val[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
         in_mod[i] = '0; tx_full[i] = 1'b0; in_st[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_in_ready", 64'(in_ready[i]), 64'(0));
         chk("rst_tx_val", 64'(tx_val[i]), 64'(0));
         chk("rst_pkt_cnt", 64'(pkt_cnt[i]), 64'(0));
         chk("rst_err_cnt", 64'(err_cnt[i]), 64'(0));
         chk("rst_ferr", 64'(ferr[i]), 64'(0));
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst_ct", 64'(in_ready[0]), 64'(1));
      chk("ready_after_rst_sf", 64'(in_ready[1]), 64'(1));

      // cut-through 4-word packet, mod 5
      send(0, 64'h1000, 1'b1, 1'b0, 3'd0, 0, a_sop);
      send(0, 64'h1001, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h1002, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h1003, 1'b0, 1'b1, 3'd5, 0, a);
      drain(0);
      chk("ct_latency", 64'(last_sop_cyc[0] - a_sop), 64'(2));
      chk("ct_run_len", 64'(last_run[0]), 64'(4));
      chk("ct_pkt_cnt1", 64'(pkt_cnt[0]), 64'(1));

      // cut-through with ingress gaps: underrun gaps, no reordering
      send(0, 64'h1100, 1'b1, 1'b0, 3'd0, 3, a);
      send(0, 64'h1101, 1'b0, 1'b0, 3'd0, 4, a);
      send(0, 64'h1102, 1'b0, 1'b1, 3'd1, 0, a);
      drain(0);
      chk("ct_pkt_cnt2", 64'(pkt_cnt[0]), 64'(2));

      // store-and-forward 3-word packet with gaps
      v0 = val_total[1];
      send(1, 64'h2000, 1'b1, 1'b0, 3'd0, 2, a);
      send(1, 64'h2001, 1'b0, 1'b0, 3'd0, 3, a);
      send(1, 64'h2002, 1'b0, 1'b1, 3'd3, 0, a_eop);
      chk("sf_hold", 64'(val_total[1] - v0), 64'(0));
      drain(1);
      chk("sf_latency_ge2", 64'((last_sop_cyc[1] - a_eop) >= 2), 64'(1));
      chk("sf_run_len", 64'(last_run[1]), 64'(3));
      chk("sf_pkt_cnt1", 64'(pkt_cnt[1]), 64'(1));

      // MAC backpressure for 5 cycles mid-packet
      send(0, 64'h3000, 1'b1, 1'b0, 3'd0, 0, a);
      send(0, 64'h3001, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h3002, 1'b0, 1'b0, 3'd0, 0, a);
      tx_full[0] = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("full_hold", 64'(tx_val[0]), 64'(0));
         @(posedge clk);
         #1;
      end
      tx_full[0] = 1'b0;
      send(0, 64'h3003, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h3004, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h3005, 1'b0, 1'b1, 3'd7, 0, a);
      drain(0);
      chk("ct_pkt_cnt3", 64'(pkt_cnt[0]), 64'(3));

      // DEPTH 4 fill with egress blocked, then forced release of a 6-word packet
      v0 = val_total[1];
      tx_full[1] = 1'b1;
      send(1, 64'h4000, 1'b1, 1'b0, 3'd0, 0, a);
      send(1, 64'h4001, 1'b0, 1'b0, 3'd0, 0, a);
      send(1, 64'h4002, 1'b0, 1'b0, 3'd0, 0, a);
      send(1, 64'h4003, 1'b0, 1'b0, 3'd0, 0, a);
      @(negedge clk);
      chk("full_not_ready", 64'(in_ready[1]), 64'(0));
      @(posedge clk);
      #1;
      tx_full[1] = 1'b0;
      send(1, 64'h4004, 1'b0, 1'b0, 3'd0, 0, a);
      send(1, 64'h4005, 1'b0, 1'b1, 3'd4, 0, a);
      drain(1);
      chk("forced_words", 64'(val_total[1] - v0), 64'(6));
      chk("sf_pkt_cnt2", 64'(pkt_cnt[1]), 64'(2));

      // framing violations: stray word in IDLE, sop inside a packet
      f0 = ferr_total[0];
      send(0, 64'h5000, 1'b0, 1'b0, 3'd0, 0, a);
      send(0, 64'h5001, 1'b1, 1'b0, 3'd0, 0, a);
      send(0, 64'h5002, 1'b1, 1'b0, 3'd0, 0, a);
      send(0, 64'h5003, 1'b0, 1'b1, 3'd2, 0, a);
      drain(0);
      chk("ferr_pulses", 64'(ferr_total[0] - f0), 64'(2));
      chk("err_cnt2", 64'(err_cnt[0]), 64'(2));
      chk("ct_pkt_cnt4", 64'(pkt_cnt[0]), 64'(4));

      // reset with two words buffered
      tx_full[0] = 1'b1;
      send(0, 64'h6000, 1'b1, 1'b0, 3'd0, 0, a);
      send(0, 64'h6001, 1'b0, 1'b0, 3'd0, 0, a);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_in_ready", 64'(in_ready[0]), 64'(0));
      chk("arst_tx_val", 64'(tx_val[0]), 64'(0));
      chk("arst_pkt_cnt", 64'(pkt_cnt[0]), 64'(0));
      chk("arst_err_cnt", 64'(err_cnt[0]), 64'(0));
      sb0.delete();
      sb1.delete();
      in_st[0] = 1'b0;
      in_st[1] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tx_full[0] = 1'b0;
      v0 = val_total[0];
      repeat (10) @(posedge clk);
      #1;
      chk("no_stale_words", 64'(val_total[0] - v0), 64'(0));
      chk("post_rst_pkt_cnt", 64'(pkt_cnt[0]), 64'(0));
      chk("post_rst_ready", 64'(in_ready[0]), 64'(1));
      send(0, 64'h7000, 1'b1, 1'b0, 3'd0, 0, a);
      send(0, 64'h7001, 1'b0, 1'b1, 3'd6, 0, a);
      drain(0);
      chk("post_rst_pkt", 64'(pkt_cnt[0]), 64'(1));
      chk("sb_ct_empty", 64'(sb_size(0)), 64'(0));
      chk("sb_sf_empty", 64'(sb_size(1)), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
